// File: rtl/fdtd_step_sequencer.sv
// Sequences one FDTD timestep: load Hy(n-1) and Ez(n-1) into the field buffer,
// run the update engine, then write one selected field back to data memory.
module fdtd_step_sequencer #(
    parameter int FDTD_DATA_WIDTH   = 32,
    parameter int BUFFER_ADDR_WIDTH = 6,
    parameter int FDTD_BUFFER_DEPTH = 64,
    parameter int DM_ADDR_WIDTH     = 32
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       step_start_i,
    input  logic [BUFFER_ADDR_WIDTH:0] step_size_i,
    input  logic [DM_ADDR_WIDTH-1:0]   hy_base_i,
    input  logic [DM_ADDR_WIDTH-1:0]   ez_base_i,
    input  logic                       wb_sel_i,
    output logic                       dm_req_o,
    output logic                       dm_we_o,
    output logic [DM_ADDR_WIDTH-1:0]   dm_addr_o,
    input  logic                       dm_gnt_i,
    input  logic                       dm_rvalid_i,
    output logic                       buffer_hy_start_o,
    output logic                       buffer_ez_start_o,
    output logic                       buffer_hy_end_o,
    output logic                       buffer_ez_end_o,
    output logic                       wrtvalid_hy_old_o,
    output logic                       wrtvalid_ez_old_o,
    output logic                       calc_start_o,
    input  logic                       calc_done_i,
    output logic                       mem_rd_hy_en_o,
    output logic                       mem_rd_ez_en_o,
    output logic                       wrtvalid_sgl_o,
    output logic                       mem_rd_end_o,
    output logic                       busy_o,
    output logic                       step_done_o,
    output logic                       err_o,
    output logic [3:0]                 dbg_state_o
);

    localparam int CW = BUFFER_ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FDTD_BUFFER_DEPTH);
    // Byte stride per field word (4 for 32-bit words, i.e. {index,2'b00}).
    localparam logic [DM_ADDR_WIDTH-1:0] WORD_BYTES = DM_ADDR_WIDTH'(FDTD_DATA_WIDTH / 8);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_ARM_HY = 4'd1,
        S_LD_HY  = 4'd2,
        S_ARM_EZ = 4'd3,
        S_LD_EZ  = 4'd4,
        S_CALC   = 4'd5,
        S_WB_SEL = 4'd6,
        S_WB_RD  = 4'd7,
        S_WB_WR  = 4'd8,
        S_WB_END = 4'd9,
        S_DONE   = 4'd10
    } state_t;

    state_t                   state_q, state_d;
    logic                     phase_q, phase_d;
    logic [CW-1:0]            idx_q, idx_d;
    logic [CW-1:0]            rcv_q, rcv_d;
    logic [CW-1:0]            size_q, size_d;
    logic [DM_ADDR_WIDTH-1:0] hy_base_q, hy_base_d;
    logic [DM_ADDR_WIDTH-1:0] ez_base_q, ez_base_d;
    logic                     wb_sel_q, wb_sel_d;
    logic                     err_q, err_d;

    logic                     idle_like;
    logic                     size_bad;
    logic [CW-1:0]            idx_inc;
    logic [DM_ADDR_WIDTH-1:0] addr_base;
    logic [DM_ADDR_WIDTH-1:0] addr_off;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            phase_q   <= 1'b0;
            idx_q     <= '0;
            rcv_q     <= '0;
            size_q    <= '0;
            hy_base_q <= '0;
            ez_base_q <= '0;
            wb_sel_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            idx_q     <= idx_d;
            rcv_q     <= rcv_d;
            size_q    <= size_d;
            hy_base_q <= hy_base_d;
            ez_base_q <= ez_base_d;
            wb_sel_q  <= wb_sel_d;
            err_q     <= err_d;
        end
    end

    // Data-memory handshake: a request transfers on a cycle with dm_req_o && dm_gnt_i;
    // dm_req_o/dm_we_o/dm_addr_o stay stable until then. Read data returns in order,
    // one dm_rvalid_i per accepted read, at least one cycle after the grant.
    always_comb begin
        state_d           = state_q;
        phase_d           = phase_q;
        idx_d             = idx_q;
        rcv_d             = rcv_q;
        size_d            = size_q;
        hy_base_d         = hy_base_q;
        ez_base_d         = ez_base_q;
        wb_sel_d          = wb_sel_q;
        err_d             = err_q;
        dm_req_o          = 1'b0;
        dm_we_o           = 1'b0;
        addr_base         = '0;
        buffer_hy_start_o = 1'b0;
        buffer_ez_start_o = 1'b0;
        buffer_hy_end_o   = 1'b0;
        buffer_ez_end_o   = 1'b0;
        wrtvalid_hy_old_o = 1'b0;
        wrtvalid_ez_old_o = 1'b0;
        calc_start_o      = 1'b0;
        mem_rd_hy_en_o    = 1'b0;
        mem_rd_ez_en_o    = 1'b0;
        wrtvalid_sgl_o    = 1'b0;
        mem_rd_end_o      = 1'b0;
        step_done_o       = 1'b0;
        idle_like         = (state_q == S_IDLE) || (state_q == S_DONE);
        size_bad          = (step_size_i == '0) || (step_size_i > DEPTH_C);
        idx_inc           = idx_q + 1'b1;

        case (state_q)
            S_IDLE: begin
            end
            // Buffer registers the start pulse, then changes state: hold two cycles.
            S_ARM_HY, S_ARM_EZ: begin
                buffer_hy_start_o = (state_q == S_ARM_HY) && !phase_q;
                buffer_ez_start_o = (state_q == S_ARM_EZ) && !phase_q;
                phase_d           = 1'b1;
                if (phase_q) begin
                    phase_d = 1'b0;
                    state_d = (state_q == S_ARM_HY) ? S_LD_HY : S_LD_EZ;
                end
            end
            S_LD_HY, S_LD_EZ: begin
                addr_base = (state_q == S_LD_HY) ? hy_base_q : ez_base_q;
                dm_req_o  = (idx_q < size_q);
                if (dm_req_o && dm_gnt_i) begin
                    idx_d = idx_inc;
                end
                if (rcv_q < size_q) begin
                    if (dm_rvalid_i) begin
                        rcv_d             = rcv_q + 1'b1;
                        wrtvalid_hy_old_o = (state_q == S_LD_HY);
                        wrtvalid_ez_old_o = (state_q == S_LD_EZ);
                    end
                end else begin
                    // All words in: close the buffer load; stray rvalids are dropped here.
                    buffer_hy_end_o = (state_q == S_LD_HY);
                    buffer_ez_end_o = (state_q == S_LD_EZ);
                    idx_d           = '0;
                    rcv_d           = '0;
                    phase_d         = 1'b0;
                    state_d         = (state_q == S_LD_HY) ? S_ARM_EZ : S_CALC;
                end
            end
            S_CALC: begin
                calc_start_o = !phase_q;
                phase_d      = 1'b1;
                if (calc_done_i) begin
                    phase_d = 1'b0;
                    state_d = S_WB_SEL;
                end
            end
            S_WB_SEL: begin
                mem_rd_hy_en_o = !phase_q && !wb_sel_q;
                mem_rd_ez_en_o = !phase_q && wb_sel_q;
                phase_d        = 1'b1;
                if (phase_q) begin
                    phase_d = 1'b0;
                    state_d = S_WB_RD;
                end
            end
            S_WB_RD: begin
                wrtvalid_sgl_o = 1'b1;
                state_d        = S_WB_WR;
            end
            S_WB_WR: begin
                addr_base = wb_sel_q ? ez_base_q : hy_base_q;
                dm_req_o  = 1'b1;
                dm_we_o   = 1'b1;
                if (dm_gnt_i) begin
                    idx_d   = idx_inc;
                    state_d = (idx_inc == size_q) ? S_WB_END : S_WB_RD;
                end
            end
            S_WB_END: begin
                mem_rd_end_o = 1'b1;
                idx_d        = '0;
                state_d      = S_DONE;
            end
            S_DONE: begin
                step_done_o = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // busy_o is already low in DONE, so a start there is honoured as in IDLE.
        if (idle_like && step_start_i) begin
            err_d   = size_bad;
            phase_d = 1'b0;
            idx_d   = '0;
            rcv_d   = '0;
            if (size_bad) begin
                state_d = S_DONE;
            end else begin
                size_d    = step_size_i;
                hy_base_d = hy_base_i;
                ez_base_d = ez_base_i;
                wb_sel_d  = wb_sel_i;
                state_d   = S_ARM_HY;
            end
        end

        addr_off  = DM_ADDR_WIDTH'(idx_q) * WORD_BYTES;
        dm_addr_o = dm_req_o ? (addr_base + addr_off) : '0;
        busy_o    = !idle_like;
    end

    assign err_o       = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fdtd_step_sequencer.sv
// Self-checking bench for fdtd_step_sequencer: table of directed steps plus
// hand sequences for ignored-input and mid-step reset corner cases.
module tb_fdtd_step_sequencer;

    typedef struct {
        logic [6:0]  size;
        logic [31:0] hy;
        logic [31:0] ez;
        logic        wb;
        int          gnt_mode;
        int          lat;
        logic        extra;
        int          e_rd;
        int          e_wr;
        int          e_v;
        int          e_one;
        int          e_hyen;
        int          e_ezen;
        int          e_err;
    } vec_t;

    // ---------------- clock / reset / DUT ----------------
    logic        CLK = 1'b0;
    logic        RST;
    logic        step_start_i;
    logic [6:0]  step_size_i;
    logic [31:0] hy_base_i, ez_base_i;
    logic        wb_sel_i;
    logic        dm_req_o, dm_we_o;
    logic [31:0] dm_addr_o;
    logic        dm_gnt_i, dm_rvalid_i;
    logic        buffer_hy_start_o, buffer_ez_start_o, buffer_hy_end_o, buffer_ez_end_o;
    logic        wrtvalid_hy_old_o, wrtvalid_ez_old_o, calc_start_o, calc_done_i;
    logic        calc_done_rsp, calc_done_noise;
    logic        mem_rd_hy_en_o, mem_rd_ez_en_o, wrtvalid_sgl_o, mem_rd_end_o;
    logic        busy_o, step_done_o, err_o;
    logic [3:0]  dbg_state_o;

    always #5 CLK = ~CLK;
    assign calc_done_i = calc_done_rsp | calc_done_noise;

    fdtd_step_sequencer dut (
        .CLK(CLK), .RST(RST),
        .step_start_i(step_start_i), .step_size_i(step_size_i),
        .hy_base_i(hy_base_i), .ez_base_i(ez_base_i), .wb_sel_i(wb_sel_i),
        .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o),
        .dm_gnt_i(dm_gnt_i), .dm_rvalid_i(dm_rvalid_i),
        .buffer_hy_start_o(buffer_hy_start_o), .buffer_ez_start_o(buffer_ez_start_o),
        .buffer_hy_end_o(buffer_hy_end_o), .buffer_ez_end_o(buffer_ez_end_o),
        .wrtvalid_hy_old_o(wrtvalid_hy_old_o), .wrtvalid_ez_old_o(wrtvalid_ez_old_o),
        .calc_start_o(calc_start_o), .calc_done_i(calc_done_i),
        .mem_rd_hy_en_o(mem_rd_hy_en_o), .mem_rd_ez_en_o(mem_rd_ez_en_o),
        .wrtvalid_sgl_o(wrtvalid_sgl_o), .mem_rd_end_o(mem_rd_end_o),
        .busy_o(busy_o), .step_done_o(step_done_o), .err_o(err_o),
        .dbg_state_o(dbg_state_o)
    );

    // ---------------- memory / engine responder ----------------
    int          cfg_gnt_mode = 0;
    int          cfg_lat = 2;
    logic        cfg_extra = 1'b0;
    logic [31:0] cfg_last_hy = '0;
    logic [7:0]  pend = '0;
    logic        gnt_tog = 1'b0;
    int          calc_cnt = 0;
    int          cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK) begin
        #1;
        gnt_tog  = ~gnt_tog;
        dm_gnt_i = (cfg_gnt_mode == 0) ? 1'b1 : gnt_tog;
        if (RST) begin
            pend          = '0;
            calc_cnt      = 0;
            calc_done_rsp = 1'b0;
            dm_rvalid_i   = 1'b0;
        end else begin
            pend        = pend >> 1;
            dm_rvalid_i = pend[0];
            if (dm_req_o && dm_gnt_i && !dm_we_o) begin
                pend[cfg_lat] = 1'b1;
                if (cfg_extra && dm_addr_o == cfg_last_hy) pend[cfg_lat + 1] = 1'b1;
            end
            calc_done_rsp = 1'b0;
            if (calc_cnt > 0) begin
                calc_cnt = calc_cnt - 1;
                if (calc_cnt == 0) calc_done_rsp = 1'b1;
            end
            if (calc_start_o) calc_cnt = 3;
        end
    end

    // ---------------- monitor (samples on falling edge) ----------------
    logic        mon_clear = 1'b0;
    logic [32:0] obs_q[$];
    logic [32:0] exp_q[$];
    int n_rd, n_wr, n_vhy, n_vez, n_sgl, n_hyen, n_ezen, n_hys, n_ezs;
    int n_hyend, n_ezend, n_calc, n_rdend, n_done;
    int last_vhy_cyc, hyend_cyc, hys_cyc, first_req_cyc;
    logic any_req, busy_at_done, busy_low_in_req;

    always @(negedge CLK) begin
        if (mon_clear) begin
            n_rd = 0; n_wr = 0; n_vhy = 0; n_vez = 0; n_sgl = 0; n_hyen = 0; n_ezen = 0;
            n_hys = 0; n_ezs = 0; n_hyend = 0; n_ezend = 0; n_calc = 0; n_rdend = 0; n_done = 0;
            last_vhy_cyc = -100; hyend_cyc = 0; hys_cyc = 0; first_req_cyc = -1;
            any_req = 1'b0; busy_at_done = 1'b1; busy_low_in_req = 1'b0;
            obs_q.delete();
        end else if (!RST) begin
            if (dm_req_o) begin
                any_req = 1'b1;
                if (!busy_o) busy_low_in_req = 1'b1;
                if (first_req_cyc < 0) first_req_cyc = cyc;
            end
            if (dm_req_o && dm_gnt_i) begin
                if (dm_we_o) n_wr++; else n_rd++;
                obs_q.push_back({dm_we_o, dm_addr_o});
            end
            if (wrtvalid_hy_old_o) begin n_vhy++; last_vhy_cyc = cyc; end
            if (wrtvalid_ez_old_o) n_vez++;
            if (wrtvalid_sgl_o) n_sgl++;
            if (mem_rd_hy_en_o) n_hyen++;
            if (mem_rd_ez_en_o) n_ezen++;
            if (buffer_hy_start_o) begin n_hys++; hys_cyc = cyc; end
            if (buffer_ez_start_o) n_ezs++;
            if (buffer_hy_end_o) begin n_hyend++; hyend_cyc = cyc; end
            if (buffer_ez_end_o) n_ezend++;
            if (calc_start_o) n_calc++;
            if (mem_rd_end_o) n_rdend++;
            if (step_done_o) begin n_done++; busy_at_done = busy_o; end
        end
    end

    // ---------------- scoreboard helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int sz, input logic [31:0] hy, input logic [31:0] ez,
                                input logic wb, input int gm, input int lat, input logic extra,
                                input int e_rd, input int e_wr, input int e_v, input int e_one,
                                input int e_hyen, input int e_ezen, input int e_err);
        vec_t v;
        v.size = 7'(sz); v.hy = hy; v.ez = ez; v.wb = wb; v.gnt_mode = gm; v.lat = lat;
        v.extra = extra; v.e_rd = e_rd; v.e_wr = e_wr; v.e_v = e_v; v.e_one = e_one;
        v.e_hyen = e_hyen; v.e_ezen = e_ezen; v.e_err = e_err;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic begin_step(input vec_t v);
        @(negedge CLK);
        mon_clear = 1'b1;
        @(negedge CLK);
        #1 mon_clear = 1'b0;
        cfg_gnt_mode = v.gnt_mode;
        cfg_lat      = v.lat;
        cfg_extra    = v.extra;
        cfg_last_hy  = v.hy + 32'(4 * (int'(v.size) - 1));
        step_size_i  = v.size;
        hy_base_i    = v.hy;
        ez_base_i    = v.ez;
        wb_sel_i     = v.wb;
        exp_q.delete();
        if (v.e_one != 0) begin
            for (int i = 0; i < int'(v.size); i++) exp_q.push_back({1'b0, v.hy + 32'(4 * i)});
            for (int i = 0; i < int'(v.size); i++) exp_q.push_back({1'b0, v.ez + 32'(4 * i)});
            for (int i = 0; i < int'(v.size); i++)
                exp_q.push_back({1'b1, (v.wb ? v.ez : v.hy) + 32'(4 * i)});
        end
        @(posedge CLK);
        #1 step_start_i = 1'b1;
        @(posedge CLK);
        #1 step_start_i = 1'b0;
    endtask

    task automatic finish_step(input vec_t v, input string nm);
        int n;
        for (int k = 0; k < 4000 && n_done == 0; k++) @(posedge CLK);
        repeat (4) @(posedge CLK);
        #1;
        check({nm, "_done_cnt"}, n_done, 1);
        check({nm, "_busy_at_done"}, busy_at_done, 0);
        check({nm, "_busy_during_req"}, busy_low_in_req, 0);
        check({nm, "_err"}, err_o, v.e_err);
        check({nm, "_any_req"}, any_req, v.e_one);
        check({nm, "_reads"}, n_rd, v.e_rd);
        check({nm, "_writes"}, n_wr, v.e_wr);
        check({nm, "_vhy"}, n_vhy, v.e_v);
        check({nm, "_vez"}, n_vez, v.e_v);
        check({nm, "_sgl"}, n_sgl, v.e_wr);
        check({nm, "_hyen"}, n_hyen, v.e_hyen);
        check({nm, "_ezen"}, n_ezen, v.e_ezen);
        check({nm, "_hy_start"}, n_hys, v.e_one);
        check({nm, "_ez_start"}, n_ezs, v.e_one);
        check({nm, "_hy_end"}, n_hyend, v.e_one);
        check({nm, "_ez_end"}, n_ezend, v.e_one);
        check({nm, "_calc_start"}, n_calc, v.e_one);
        check({nm, "_rd_end"}, n_rdend, v.e_one);
        if (v.e_one != 0) begin
            check({nm, "_hy_end_lag"}, hyend_cyc - last_vhy_cyc, 1);
            check({nm, "_arm_lag"}, first_req_cyc - hys_cyc, 2);
        end
        check({nm, "_txn_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_txn%0d", nm, i), obs_q[i], exp_q[i]);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        begin_step(v);
        finish_step(v, nm);
    endtask

    // ---------------- test sequence ----------------
    vec_t        vecs[6];
    vec_t        vn, vr, v2;
    logic        found;
    logic [16:0] out_bus;

    initial begin
        RST = 1'b1;
        step_start_i = 1'b0; step_size_i = '0; hy_base_i = '0; ez_base_i = '0; wb_sel_i = 1'b0;
        dm_gnt_i = 1'b0; dm_rvalid_i = 1'b0; calc_done_rsp = 1'b0; calc_done_noise = 1'b0;

        //           size  hy_base        ez_base        wb  gnt lat ext  rd  wr  v  one hyen ezen err
        vecs[0] = mk(4,   32'h0000_1000, 32'h0000_2000, 0,  0,  2,  0,   8,  4,  4, 1,  1,   0,   0);
        vecs[1] = mk(64,  32'h0000_4000, 32'h0000_8000, 1,  1,  2,  0, 128, 64, 64, 1,  0,   1,   0);
        vecs[2] = mk(0,   32'h0000_1000, 32'h0000_2000, 0,  0,  2,  0,   0,  0,  0, 0,  0,   0,   1);
        vecs[3] = mk(65,  32'h0000_1000, 32'h0000_2000, 0,  0,  2,  0,   0,  0,  0, 0,  0,   0,   1);
        vecs[4] = mk(1,   32'h0000_0300, 32'h0000_0400, 0,  0,  1,  1,   2,  1,  1, 1,  1,   0,   0);
        vecs[5] = mk(4,   32'hFFFF_FFF8, 32'h0001_0000, 1,  1,  3,  0,   8,  4,  4, 1,  0,   1,   0);

        repeat (3) @(posedge CLK);
        #1;
        out_bus = {dm_req_o, dm_we_o, |dm_addr_o, buffer_hy_start_o, buffer_ez_start_o,
                   buffer_hy_end_o, buffer_ez_end_o, wrtvalid_hy_old_o, wrtvalid_ez_old_o,
                   calc_start_o, mem_rd_hy_en_o, mem_rd_ez_en_o, wrtvalid_sgl_o,
                   mem_rd_end_o, busy_o, step_done_o, err_o};
        check("reset_outputs", out_bus, 0);
        check("reset_state", dbg_state_o, 0);
        @(negedge CLK) RST = 1'b0;
        repeat (2) @(posedge CLK);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // calc_done during LD_HY and a new start during LD_EZ must both be ignored.
        vn = mk(8, 32'h0000_0100, 32'h0000_0200, 0, 0, 2, 0, 16, 8, 8, 1, 1, 0, 0);
        begin_step(vn);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(posedge CLK); #1;
            if (dm_req_o && !dm_we_o) found = 1'b1;
        end
        check("noise_ld_hy_seen", found, 1);
        calc_done_noise = 1'b1;
        @(posedge CLK);
        #1 calc_done_noise = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(posedge CLK); #1;
            if (buffer_ez_start_o) found = 1'b1;
        end
        check("noise_ez_start_seen", found, 1);
        repeat (2) begin @(posedge CLK); #1; end
        step_size_i  = 7'd3;
        hy_base_i    = 32'h0000_7000;
        step_start_i = 1'b1;
        @(posedge CLK);
        #1 step_start_i = 1'b0;
        finish_step(vn, "noise");

        // Asynchronous reset while a writeback request is outstanding.
        vr = mk(4, 32'h0000_0500, 32'h0000_0600, 0, 1, 2, 0, 8, 4, 4, 1, 1, 0, 0);
        begin_step(vr);
        found = 1'b0;
        for (int k = 0; k < 600 && !found; k++) begin
            @(posedge CLK); #1;
            if (dm_req_o && dm_we_o) found = 1'b1;
        end
        check("rst_wb_wr_seen", found, 1);
        RST = 1'b1;
        #1;
        out_bus = {dm_req_o, dm_we_o, |dm_addr_o, buffer_hy_start_o, buffer_ez_start_o,
                   buffer_hy_end_o, buffer_ez_end_o, wrtvalid_hy_old_o, wrtvalid_ez_old_o,
                   calc_start_o, mem_rd_hy_en_o, mem_rd_ez_en_o, wrtvalid_sgl_o,
                   mem_rd_end_o, busy_o, step_done_o, err_o};
        check("rst_mid_outputs", out_bus, 0);
        check("rst_mid_state", dbg_state_o, 0);
        @(negedge CLK) RST = 1'b0;
        repeat (2) @(posedge CLK);
        v2 = mk(2, 32'h0000_0A00, 32'h0000_0B00, 0, 0, 2, 0, 4, 2, 2, 1, 1, 0, 0);
        run_vec(v2, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
